cdc_sync_delay: RTL and testbench



---
 rtl/cdc_sync_delay.sv | 93 +++++++++
 tb/tb_cdc_sync_delay.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_sync_delay.sv
// Multi-bit clock-domain crossing: source launch register, N-flop synchronizer into clk,
// optional Gray encode/decode around the crossing, then a configurable output pipeline.
module cdc_sync_delay #(
    parameter int DWID     = 10,
    parameter int SYNC_NUM = 3,
    parameter int PIPE_NUM = 1,
    parameter int GRAY_EN  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            src_clk,
    input  logic            src_rst,
    input  logic [DWID-1:0] din,
    output logic [DWID-1:0] dout
);

    generate
        if (SYNC_NUM < 2) begin : g_bad_sync_num
            $fatal(1, "cdc_sync_delay: SYNC_NUM must be >= 2");
        end
    endgenerate

    logic [DWID-1:0] launch_d;
    logic [DWID-1:0] launch_q;

    assign launch_d = (GRAY_EN != 0) ? (din ^ (din >> 1)) : din;

    // Only this register output may cross; nothing combinational reaches the destination domain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            launch_q <= '0;
        end else begin
            launch_q <= launch_d;
        end
    end

    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [DWID-1:0] sync_q [SYNC_NUM];

    // NOTE: the synchronizer array is a chain of flops, not a RAM, so every stage is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_NUM; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= launch_q;
            for (int k = 1; k < SYNC_NUM; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    logic [DWID-1:0] sync_last;
    logic [DWID-1:0] bin;

    assign sync_last = sync_q[SYNC_NUM-1];

    // Gray decode: binary bit i is the XOR of all Gray bits at and above i.
    // NOTE: bin is assigned before any conditional update so no latch is inferred.
    always_comb begin
        bin = sync_last;
        if (GRAY_EN != 0) begin
            for (int i = 0; i < DWID; i++) begin
                bin[i] = ^(sync_last >> i);
            end
        end
    end

    generate
        if (PIPE_NUM == 0) begin : g_no_pipe
            assign dout = bin;
        end else begin : g_pipe
            logic [DWID-1:0] pipe_q [PIPE_NUM];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < PIPE_NUM; k++) begin
                        pipe_q[k] <= '0;
                    end
                end else begin
                    pipe_q[0] <= bin;
                    for (int k = 1; k < PIPE_NUM; k++) begin
                        pipe_q[k] <= pipe_q[k-1];
                    end
                end
            end

            assign dout = pipe_q[PIPE_NUM-1];
        end
    endgenerate

endmodule

// File: tb/tb_cdc_sync_delay.sv
// Scoreboard bench for cdc_sync_delay: three same-clock latency variants plus a
// Gray-coded counter crossing from a 100 MHz-like source into a 37 MHz-like destination.
module tb_cdc_sync_delay;

    typedef struct packed {
        logic [9:0] val;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       src_rst;
    logic [9:0] din_a;
    logic [9:0] dout_a;
    logic [9:0] dout_b;
    logic [9:0] dout_c;

    logic       clk_g;
    logic       src_clk_g;
    logic       rst_g;
    logic       src_rst_g;
    logic [9:0] din_g;
    logic [9:0] dout_g;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [9:0] gq[$];

    // Same-clock instances: latencies 5, 4 and 3 edges.
    cdc_sync_delay #(.DWID(10), .SYNC_NUM(3), .PIPE_NUM(1), .GRAY_EN(0)) u_dut (
        .clk(clk), .rst(rst), .src_clk(clk), .src_rst(src_rst), .din(din_a), .dout(dout_a));
    cdc_sync_delay #(.DWID(10), .SYNC_NUM(3), .PIPE_NUM(0), .GRAY_EN(0)) u_p0 (
        .clk(clk), .rst(rst), .src_clk(clk), .src_rst(src_rst), .din(din_a), .dout(dout_b));
    cdc_sync_delay #(.DWID(10), .SYNC_NUM(2), .PIPE_NUM(0), .GRAY_EN(0)) u_s2 (
        .clk(clk), .rst(rst), .src_clk(clk), .src_rst(src_rst), .din(din_a), .dout(dout_c));
    cdc_sync_delay #(.DWID(10), .SYNC_NUM(3), .PIPE_NUM(1), .GRAY_EN(1)) u_gray (
        .clk(clk_g), .rst(rst_g), .src_clk(src_clk_g), .src_rst(src_rst_g), .din(din_g), .dout(dout_g));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        clk_g = 1'b0;
        forever begin
            #13 clk_g = 1'b1;
            #14 clk_g = 1'b0;
        end
    end

    initial begin
        src_clk_g = 1'b0;
        #3;
        forever #5 src_clk_g = ~src_clk_g;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        case (k)
            0:       return 5;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    // Expected change cycle = base + (latency if use_lat) + delta.
    task automatic expect_all(input logic [9:0] v, input int base, input bit use_lat, input int delta);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.val = v;
            e.cyc = base + (use_lat ? lat_of(k) : 0) + delta;
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic pop_exp(input int k, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        case (k)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Same-clock monitor: every dout change must match the next expected value and cycle.
    logic [9:0] prev_sc [3] = '{10'h000, 10'h000, 10'h000};
    always @(negedge clk) begin
        logic [9:0] cur [3];
        exp_t e;
        bit   ok;
        cur[0] = dout_a;
        cur[1] = dout_b;
        cur[2] = dout_c;
        for (int k = 0; k < 3; k++) begin
            if (cur[k] !== prev_sc[k]) begin
                pop_exp(k, e, ok);
                if (!ok) begin
                    check($sformatf("sc%0d_unexpected_change", k), {22'd0, cur[k]}, {22'd0, prev_sc[k]});
                end else begin
                    check($sformatf("sc%0d_value", k), {22'd0, cur[k]}, {22'd0, e.val});
                    check($sformatf("sc%0d_cycle", k), cyc, e.cyc);
                end
                prev_sc[k] = cur[k];
            end
        end
    end

    // Gray monitor: each new dout must be one of the next few din values, in order.
    logic [9:0] prev_g = 10'h000;
    always @(negedge clk_g) begin
        int         n;
        bit         found;
        logic [9:0] v;
        if (dout_g !== prev_g) begin
            n     = 0;
            found = 1'b0;
            while (gq.size() > 0 && !found) begin
                v = gq.pop_front();
                n++;
                if (v == dout_g) found = 1'b1;
            end
            check("gray_value_seen", {31'd0, found}, 32'd1);
            check("gray_step_le4", {31'd0, (n <= 4)}, 32'd1);
            prev_g = dout_g;
        end
    end

    task automatic step_sc(input logic [9:0] v);
        @(posedge clk);
        #2;
        din_a = v;
        expect_all(v, cyc, 1'b1, 0);
        repeat (10) @(posedge clk);
    endtask

    task automatic run_sc();
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_a", {22'd0, dout_a}, 32'h0);
            check("rst_hold_b", {22'd0, dout_b}, 32'h0);
            check("rst_hold_c", {22'd0, dout_c}, 32'h0);
        end
        @(posedge clk);
        #2;
        rst     = 1'b0;
        src_rst = 1'b0;
        expect_all(10'h3FF, cyc, 1'b1, 0);
        repeat (10) @(posedge clk);

        step_sc(10'h000);
        step_sc(10'h155);
        step_sc(10'h0AA);
        step_sc(10'h2A5);

        // One-cycle destination reset with din stable.
        @(posedge clk);
        #2;
        rst = 1'b1;
        expect_all(10'h000, cyc, 1'b0, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        expect_all(10'h2A5, cyc, 1'b1, -1);
        repeat (10) @(posedge clk);

        step_sc(10'h123);

        // Source reset pulse: 0 crosses, then din re-launches after release.
        @(posedge clk);
        #2;
        src_rst = 1'b1;
        expect_all(10'h000, cyc, 1'b1, -1);
        repeat (6) @(posedge clk);
        #2;
        src_rst = 1'b0;
        expect_all(10'h123, cyc, 1'b1, 0);
        repeat (10) @(posedge clk);

        check("sc0_queue_drained", q0.size(), 32'd0);
        check("sc1_queue_drained", q1.size(), 32'd0);
        check("sc2_queue_drained", q2.size(), 32'd0);
    endtask

    task automatic drive_gray(input logic [9:0] v);
        @(posedge src_clk_g);
        #1;
        din_g = v;
        gq.push_back(v);
    endtask

    task automatic run_gray();
        repeat (3) @(posedge clk_g);
        #1;
        rst_g     = 1'b0;
        src_rst_g = 1'b0;
        for (int v = 1; v < 1024; v++) drive_gray(10'(v));
        repeat (12) @(posedge clk_g);
        @(negedge clk_g);
        check("gray_hold_3ff", {22'd0, dout_g}, 32'h3FF);
        check("gray_queue_3ff", gq.size(), 32'd0);

        // Wrap boundary: the only change allowed after 0x3FF is 0x000.
        drive_gray(10'h000);
        repeat (12) @(posedge clk_g);
        @(negedge clk_g);
        check("gray_wrap_000", {22'd0, dout_g}, 32'h000);

        for (int v = 1; v < 16; v++) drive_gray(10'(v));
        repeat (12) @(posedge clk_g);
        @(negedge clk_g);
        check("gray_final_00f", {22'd0, dout_g}, 32'h00F);
        check("gray_queue_final", gq.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        src_rst   = 1'b1;
        din_a     = 10'h3FF;
        rst_g     = 1'b1;
        src_rst_g = 1'b1;
        din_g     = 10'h000;
        fork
            run_sc();
            run_gray();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
